// File: rtl/led_pattern_pkg.sv
// Shared types and sizing helpers for the multi-channel LED pattern controller.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  // Channel-select width: at least one bit even for a single channel.
  function automatic int chWidth(input int nCh);
    return (nCh <= 2) ? 1 : $clog2(nCh);
  endfunction

  // Prescaler width needed to count 0..div-1.
  function automatic int prescWidth(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, blink phase counter, breathe ramp and
// the registered LED drive.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter int DIV_W      = 16,
  parameter int DEF_HALF   = 500,
  parameter bit INIT_PHASE = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             wr_i,
  input  mode_t            mode_i,
  input  logic [PWM_W-1:0] duty_i,
  input  logic [DIV_W-1:0] half_i,
  output logic             led_o
);

  localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(DEF_HALF);
  localparam logic [PWM_W-1:0] LVL_MAX  = '1;

  mode_t            mode_q, mode_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [PWM_W-1:0] level_q, level_d;
  logic             dirUp_q, dirUp_d;
  logic             led_q, led_d;
  logic [DIV_W-1:0] halfLast;

  // Full-scale duty means solidly on, not on for all-but-one PWM step.
  function automatic logic pwmOn(input logic [PWM_W-1:0] d, input logic [PWM_W-1:0] cnt);
    return (d == LVL_MAX) || (cnt < d);
  endfunction

  // A config write replaces the tick for this channel; otherwise each tick advances the blink and breathe counters.
  always_comb begin
    mode_d   = mode_q;
    duty_d   = duty_q;
    half_d   = half_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    level_d  = level_q;
    dirUp_d  = dirUp_q;
    halfLast = (half_q == '0) ? '0 : half_q - DIV_W'(1);
    if (wr_i) begin
      mode_d  = mode_i;
      duty_d  = duty_i;
      half_d  = half_i;
      cnt_d   = '0;
      phase_d = 1'b1;
      level_d = '0;
      dirUp_d = 1'b1;
    end else if (tick_i) begin
      if (cnt_q >= halfLast) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      if (dirUp_q) begin
        level_d = level_q + PWM_W'(1);
        if (level_q == LVL_MAX - PWM_W'(1)) dirUp_d = 1'b0;
      end else begin
        level_d = level_q - PWM_W'(1);
        if (level_q == PWM_W'(1)) dirUp_d = 1'b1;
      end
    end
  end

  // LED drive is computed from the current state and registered, giving one cycle of latency.
  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_ON:      led_d = pwmOn(duty_q, pwm_cnt_i);
      MODE_BLINK:   led_d = phase_q & pwmOn(duty_q, pwm_cnt_i);
      MODE_BREATHE: led_d = pwmOn(level_q, pwm_cnt_i);
      default:      led_d = 1'b0;
    endcase
  end

  // Channel state registers with synchronous reset to blinking at full brightness.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q  <= MODE_BLINK;
      duty_q  <= '1;
      half_q  <= HALF_RST;
      cnt_q   <= '0;
      phase_q <= INIT_PHASE;
      level_q <= '0;
      dirUp_q <= 1'b1;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      level_q <= level_d;
      dirUp_q <= dirUp_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern controller: shared timebase prescaler, shared PWM
// counter, single-entry config handshake and per-channel pattern engines.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ   = 125000000,
  parameter int TICK_HZ  = 1000,
  parameter int N_CH     = 2,
  parameter int PWM_W    = 8,
  parameter int DIV_W    = 16,
  parameter int DEF_HALF = 500
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CFG_WE,
  output logic                      CFG_RDY,
  input  logic [chWidth(N_CH)-1:0]  CFG_CH,
  input  logic [1:0]                CFG_MODE,
  input  logic [PWM_W-1:0]          CFG_DUTY,
  input  logic [DIV_W-1:0]          CFG_HALF,
  output logic [N_CH-1:0]           LED,
  output logic                      TICK
);

  localparam int                CH_W     = chWidth(N_CH);
  localparam int                DIV      = CLK_HZ / TICK_HZ;
  localparam int                PRE_W    = prescWidth(DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             rdy_q, rdy_d;
  logic             tick;
  logic             accept;
  logic [N_CH-1:0]  wrSel;

  // Prescaler and PWM counter both free-run and wrap; the handshake drops ready for one cycle after each accept.
  always_comb begin
    tick    = (presc_q == PRE_LAST);
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    pwm_d   = pwm_q + PWM_W'(1);
    accept  = CFG_WE & rdy_q;
    rdy_d   = ~accept;
  end

  // Decode an accepted write onto its channel; out-of-range channels match nothing.
  always_comb begin
    wrSel = '0;
    for (int k = 0; k < N_CH; k++) begin
      wrSel[k] = accept && (CFG_CH == CH_W'(k));
    end
  end

  // Shared timebase and handshake registers, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      pwm_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      rdy_q   <= rdy_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : gCh
    led_channel #(
      .PWM_W      (PWM_W),
      .DIV_W      (DIV_W),
      .DEF_HALF   (DEF_HALF),
      .INIT_PHASE (((g % 2) == 0) ? 1'b1 : 1'b0)
    ) uChan (
      .CLK       (CLK),
      .RST       (RST),
      .tick_i    (tick),
      .pwm_cnt_i (pwm_q),
      .wr_i      (wrSel[g]),
      .mode_i    (mode_t'(CFG_MODE)),
      .duty_i    (CFG_DUTY),
      .half_i    (CFG_HALF),
      .led_o     (LED[g])
    );
  end

  assign CFG_RDY = rdy_q;
  assign TICK    = tick;

endmodule
